// File: rtl/vape_er_atomic_monitor.sv
// Executable Region (ER) atomicity monitor.
// Tracks entry/exit of the ER from the fetch address and latches the first
// breach (illegal entry/exit, irq or DMA inside, write into ER, overrun)
// until the CPU restarts at RESET_PC.
module vape_er_atomic_monitor #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      pc,
    input  logic             irq,
    input  logic             dma_en,
    input  logic [15:0]      dma_addr,
    input  logic             data_wr,
    input  logic [15:0]      data_addr,
    input  logic [15:0]      ER_min,
    input  logic [15:0]      ER_max,
    input  logic [CNT_W-1:0] max_cyc,
    output logic             er_viol,
    output logic [2:0]       viol_cause,
    output logic [CNT_W-1:0] er_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [15:0]        pc_prev_reg;
    logic               er_viol_reg;
    logic [2:0]         cause_reg, cause_next;
    logic [CNT_W-1:0]   cycles_reg, cycles_next;

    logic               valid, in_er, wr_er;
    logic [2:0]         cause;
    logic               dma_addr_unused;

    // DMA target checking lives in a separate block; only dma_en matters here.
    assign dma_addr_unused = ^dma_addr;

    // Region decode; an inverted window disables every check.
    always_comb begin
        valid = (ER_min <= ER_max);
        in_er = valid && (pc >= ER_min) && (pc <= ER_max);
        wr_er = valid && data_wr && (data_addr >= ER_min) && (data_addr <= ER_max);
    end

    // Breach cause, lowest code wins when several fire together.
    always_comb begin
        cause = 3'd0;
        if (valid) begin
            if (state_reg == IDLE && in_er && pc != ER_min)
                cause = 3'd1;
            else if (state_reg == RUN && !in_er && pc_prev_reg != ER_max)
                cause = 3'd2;
            else if (state_reg == RUN && irq)
                cause = 3'd3;
            else if (state_reg == RUN && dma_en)
                cause = 3'd4;
            else if (wr_er && (state_reg == IDLE || state_reg == RUN))
                cause = 3'd5;
            else if (state_reg == RUN && max_cyc != '0 && cycles_reg >= max_cyc)
                cause = 3'd6;
        end
    end

    // Next state, latched cause and run counter.
    always_comb begin
        state_next  = state_reg;
        cause_next  = cause_reg;
        cycles_next = cycles_reg;
        case (state_reg)
            IDLE: begin
                if (!valid) begin
                    state_next = IDLE;
                end else if (cause != 3'd0) begin
                    state_next = KILL;
                    cause_next = cause;
                end else if (pc == ER_min) begin
                    state_next  = RUN;
                    cycles_next = '0;
                end
            end
            RUN: begin
                if (!valid) begin
                    state_next = IDLE;
                end else if (cause != 3'd0) begin
                    state_next = KILL;
                    cause_next = cause;
                end else if (!in_er && pc_prev_reg == ER_max) begin
                    state_next = IDLE;
                end else if (cycles_reg != '1) begin
                    // Still inside (including a loop back to ER_min): count on.
                    cycles_next = cycles_reg + 1'b1;
                end
            end
            KILL: begin
                if (pc == RESET_PC) begin
                    state_next  = IDLE;
                    cause_next  = 3'd0;
                    cycles_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cause_next = 3'd0;
            end
        endcase
    end

    // State and output registers; reset overrides any breach in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            er_viol_reg <= 1'b0;
            cause_reg   <= 3'd0;
            cycles_reg  <= '0;
            pc_prev_reg <= 16'h0000;
        end else begin
            state_reg   <= state_next;
            er_viol_reg <= (state_next == KILL);
            cause_reg   <= cause_next;
            cycles_reg  <= cycles_next;
            pc_prev_reg <= pc;
        end
    end

    assign er_viol    = er_viol_reg;
    assign viol_cause = cause_reg;
    assign er_cycles  = cycles_reg;

endmodule

// File: tb/tb_vape_er_atomic_monitor.sv
// Directed bench for the ER atomicity monitor: legal run, illegal entry,
// simultaneous breaches, timeout, reset mid-run, invalid and single-address ER.
module tb_vape_er_atomic_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        irq, dma_en, data_wr;
    logic [15:0] dma_addr, data_addr, ER_min, ER_max;
    logic [15:0] max_cyc;
    logic        er_viol;
    logic [2:0]  viol_cause;
    logic [15:0] er_cycles;

    int total_checks = 0;
    int pass_checks  = 0;

    always #5 clk = ~clk;

    vape_er_atomic_monitor #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .irq        (irq),
        .dma_en     (dma_en),
        .dma_addr   (dma_addr),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .ER_min     (ER_min),
        .ER_max     (ER_max),
        .max_cyc    (max_cyc),
        .er_viol    (er_viol),
        .viol_cause (viol_cause),
        .er_cycles  (er_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) pass_checks++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive inputs mid-cycle, clock once, then sample 1 ns after the edge.
    task automatic step(input logic [15:0] p, input logic i, input logic d,
                        input logic w, input logic [15:0] wa);
        @(negedge clk);
        pc = p; irq = i; dma_en = d; data_wr = w; data_addr = wa;
        @(posedge clk);
        #1;
        $display("t=%0t pc=%h irq=%b dma=%b wr=%b@%h -> viol=%b cause=%0d cyc=%0d",
                 $time, p, i, d, w, wa, er_viol, viol_cause, er_cycles);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] c,
                              input logic [15:0] n);
        chk({tag, ".viol"},  {31'd0, er_viol}, {31'd0, v});
        chk({tag, ".cause"}, {29'd0, viol_cause}, {29'd0, c});
        chk({tag, ".cyc"},   {16'd0, er_cycles}, {16'd0, n});
    endtask

    initial begin
        reset = 1'b1; pc = 16'hC000; irq = 0; dma_en = 0; data_wr = 0;
        dma_addr = 16'hE010; data_addr = 16'h0000;
        ER_min = 16'hE000; ER_max = 16'hE0FE; max_cyc = 16'd0;

        // Reset state
        step(16'hC000, 0, 0, 0, 16'h0);
        expect_out("reset", 0, 0, 0);
        reset = 1'b0;

        // 1 Legal run: counter increments each RUN cycle, holds on exit
        step(16'hC000, 0, 0, 0, 16'h0); expect_out("t1.idle", 0, 0, 0);
        step(16'hE000, 0, 0, 0, 16'h0); expect_out("t1.entry", 0, 0, 0);
        step(16'hE002, 0, 0, 0, 16'h0); expect_out("t1.run1", 0, 0, 1);
        step(16'hE000, 0, 0, 0, 16'h0); expect_out("t1.loop", 0, 0, 2);
        step(16'hE0FE, 0, 0, 0, 16'h0); expect_out("t1.last", 0, 0, 3);
        step(16'hC010, 0, 0, 0, 16'h0); expect_out("t1.exit", 0, 0, 3);
        step(16'hC012, 0, 0, 0, 16'h0); expect_out("t1.out", 0, 0, 3);

        // 2 Mid-entry, then CPU restart clears
        step(16'hC000, 0, 0, 0, 16'h0); expect_out("t2.pre", 0, 0, 3);
        step(16'hE010, 0, 0, 0, 16'h0); expect_out("t2.entry", 1, 1, 3);
        step(16'hC000, 0, 0, 0, 16'h0); expect_out("t2.hold", 1, 1, 3);
        step(16'h0000, 0, 0, 0, 16'h0); expect_out("t2.clear", 0, 0, 0);

        // 3 Simultaneous irq+dma+write -> 3, later breaches ignored
        step(16'hE000, 0, 0, 0, 16'h0);    expect_out("t3.entry", 0, 0, 0);
        step(16'hE002, 1, 1, 1, 16'hE020); expect_out("t3.multi", 1, 3, 0);
        step(16'hE044, 1, 1, 1, 16'hE020); expect_out("t3.sticky", 1, 3, 0);
        step(16'h0000, 0, 0, 0, 16'h0);    expect_out("t3.clear", 0, 0, 0);

        // dma+write -> 4 wins over 5
        step(16'hE000, 0, 0, 0, 16'h0);    expect_out("c4.entry", 0, 0, 0);
        step(16'hE002, 0, 1, 1, 16'hE0FE); expect_out("c4.dma", 1, 4, 0);
        step(16'h0000, 0, 0, 0, 16'h0);    expect_out("c4.clear", 0, 0, 0);

        // write into ER from IDLE -> 5 (write at the inclusive top bound)
        step(16'hC000, 0, 0, 1, 16'hE0FE); expect_out("c5.wr", 1, 5, 0);
        step(16'h0000, 0, 0, 0, 16'h0);    expect_out("c5.clear", 0, 0, 0);
        step(16'hC000, 0, 0, 1, 16'hE100); expect_out("c5.outside", 0, 0, 0);

        // 4 Timeout with max_cyc=5
        max_cyc = 16'd5;
        step(16'hE000, 0, 0, 0, 16'h0); expect_out("t4.entry", 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(16'hE000 + 16'(2*k), 0, 0, 0, 16'h0);
            expect_out("t4.run", 0, 0, 16'(k));
        end
        step(16'hE00C, 0, 0, 0, 16'h0); expect_out("t4.timeout", 1, 6, 5);
        step(16'h0000, 0, 0, 0, 16'h0); expect_out("t4.clear", 0, 0, 0);

        // Same with no limit
        max_cyc = 16'd0;
        step(16'hE000, 0, 0, 0, 16'h0); expect_out("t4b.entry", 0, 0, 0);
        for (int k = 1; k <= 7; k++)
            step(16'hE000 + 16'(2*k), 0, 0, 0, 16'h0);
        expect_out("t4b.run", 0, 0, 7);
        step(16'hE0FE, 0, 0, 0, 16'h0); expect_out("t4b.last", 0, 0, 8);
        step(16'hC000, 0, 0, 0, 16'h0); expect_out("t4b.exit", 0, 0, 8);

        // Illegal exit -> 2
        step(16'hE000, 0, 0, 0, 16'h0); expect_out("c2.entry", 0, 0, 0);
        step(16'hE002, 0, 0, 0, 16'h0); expect_out("c2.run", 0, 0, 1);
        step(16'hC000, 0, 0, 0, 16'h0); expect_out("c2.exit", 1, 2, 1);
        step(16'h0000, 0, 0, 0, 16'h0); expect_out("c2.clear", 0, 0, 0);

        // 5 Reset in the same cycle as an illegal exit
        step(16'hE000, 0, 0, 0, 16'h0); expect_out("t5.entry", 0, 0, 0);
        step(16'hE002, 0, 0, 0, 16'h0); expect_out("t5.run", 0, 0, 1);
        reset = 1'b1;
        step(16'hC000, 0, 0, 0, 16'h0); expect_out("t5.reset", 0, 0, 0);
        reset = 1'b0;
        step(16'hC000, 0, 0, 0, 16'h0); expect_out("t5.after", 0, 0, 0);

        // Invalid region: nothing fires
        ER_min = 16'hF000; ER_max = 16'hE000;
        step(16'hE800, 1, 1, 1, 16'hE800); expect_out("inv", 0, 0, 0);

        // Single-address ER: entry and exit at the same address
        ER_min = 16'hD000; ER_max = 16'hD000;
        step(16'hC000, 0, 0, 0, 16'h0); expect_out("one.pre", 0, 0, 0);
        step(16'hD000, 0, 0, 0, 16'h0); expect_out("one.entry", 0, 0, 0);
        step(16'hC004, 0, 0, 0, 16'h0); expect_out("one.exit", 0, 0, 0);
        step(16'hC006, 1, 0, 0, 16'h0); expect_out("one.idle_irq", 0, 0, 0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
